// File: rtl/crt_sp_pkg.sv
// Shared types and constants for the CRT display-start scheduler.
package crt_sp_pkg;

   localparam int CRT_DSTART_AW         = 21;
   localparam int CRT_DSTART_FIFO_DEPTH = 4;
   localparam logic [7:0] CRT_LOST_MAX  = 8'd255;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      DEFER  = 2'd2,
      COMMIT = 2'd3
   } crt_dstart_state_e;

   // Up to two requests can be lost in one cycle (collision plus overwrite).
   function automatic logic [7:0] lost_sat_add(input logic [7:0] cnt, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, cnt} + {7'd0, inc};
      return (sum > {1'b0, CRT_LOST_MAX}) ? CRT_LOST_MAX : sum[7:0];
   endfunction

endpackage

// File: rtl/crt_dstart_fifo.sv
// Pending-address store: push/pop with overwrite-newest when full; zero-latency head.
// Never blocks a push; a push into a full store replaces the newest entry unless a pop frees space.
module crt_dstart_fifo #(
   parameter int W     = 21,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] head_dat,
   output logic         full,
   output logic         empty,
   output logic         multi
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] count;
   logic          do_pop;
   logic          ovw;

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign multi  = (count > CW'(1));
   assign do_pop = pop & ~empty;
   assign ovw    = push & full & ~do_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else begin
         count <= count + CW'(push & ~ovw) - CW'(do_pop);
      end
   end

   generate
      if (DEPTH == 1) begin : g_slot
         logic [W-1:0] slot;

         always_ff @(posedge clk) begin
            if (push) begin
               slot <= push_dat;
            end
         end

         assign head_dat = slot;
      end else begin : g_ring
         localparam int PW = $clog2(DEPTH);

         logic [W-1:0]  mem [DEPTH];
         logic [PW-1:0] rd_ptr;
         logic [PW-1:0] wr_ptr;
         logic [PW-1:0] wr_last;

         function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
            return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
         endfunction

         assign wr_last = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - PW'(1);

         // Overwrite lands on the most recently written slot, leaving older entries intact.
         always_ff @(posedge clk) begin
            if (push) begin
               mem[ovw ? wr_last : wr_ptr] <= push_dat;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               rd_ptr <= '0;
               wr_ptr <= '0;
            end else begin
               if (push && !ovw) begin
                  wr_ptr <= nxt(wr_ptr);
               end
               if (do_pop) begin
                  rd_ptr <= nxt(rd_ptr);
               end
            end
         end

         assign head_dat = mem[rd_ptr];
      end
   endgenerate

endmodule

// File: rtl/crt_dstart_sched.sv
// Commits host/DLP display-start writes at vblank rise (+1 cycle), deferring guard-window writes a frame.
// Requests are never stalled; excess requests overwrite pending ones. CRT_DSTART_FIFO_EN selects 4-deep storage.
module crt_dstart_sched
   import crt_sp_pkg::*;
#(
   parameter int DLP_PRIO    = 0,
   parameter int GUARD_LINES = 4,
   parameter int AW          = CRT_DSTART_AW
) (
   input  logic          hclock,
   input  logic          hreset,
   input  logic          hst_wr,
   input  logic [AW-1:0] hst_add,
   input  logic          dlp_wradd,
   input  logic [AW-1:0] dlp_add,
   input  logic          vblnkst,
   input  logic [11:0]   lcounter_stat,
   input  logic [11:0]   vactive,
   output logic [AW-1:0] dstart_act,
   output logic          ad_strst,
   output logic          addr_stat,
   output logic          dlp_ack,
   output logic          hst_ack,
   output logic [7:0]    lost_cnt
);

`ifdef CRT_DSTART_FIFO_EN
   localparam int DEPTH = CRT_DSTART_FIFO_DEPTH;
`else
   localparam int DEPTH = 1;
`endif

   crt_dstart_state_e state, state_n;

   logic          vblnkst_q;
   logic          vb_rise;
   logic [12:0]   guard_sum;
   logic          guard;
   logic          accept;
   logic          collide;
   logic [AW-1:0] win_add;
   logic          pop;
   logic [AW-1:0] head_dat;
   logic          full;
   logic          empty;
   logic          multi;
   logic [1:0]    lost_inc;

   assign vb_rise   = vblnkst & ~vblnkst_q;
   assign guard_sum = {1'b0, lcounter_stat} + 13'(GUARD_LINES);
   assign guard     = (guard_sum >= {1'b0, vactive}) & ~vblnkst;

   assign accept  = hst_wr | dlp_wradd;
   assign collide = hst_wr & dlp_wradd;
   assign win_add = collide ? ((DLP_PRIO != 0) ? dlp_add : hst_add)
                            : (dlp_wradd ? dlp_add : hst_add);

   assign pop      = (state == COMMIT);
   assign lost_inc = {1'b0, collide} + {1'b0, accept & full & ~pop};

   crt_dstart_fifo #(
      .W     (AW),
      .DEPTH (DEPTH)
   ) u_store (
      .clk      (hclock),
      .rst      (hreset),
      .push     (accept),
      .push_dat (win_add),
      .pop      (pop),
      .head_dat (head_dat),
      .full     (full),
      .empty    (empty),
      .multi    (multi)
   );

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_n = guard ? DEFER : ARMED;
            end
         end
         ARMED: begin
            if (vb_rise) begin
               state_n = COMMIT;
            end else if (accept && guard) begin
               state_n = DEFER;
            end
         end
         DEFER: begin
            if (vb_rise) begin
               state_n = ARMED;
            end
         end
         COMMIT: begin
            if (accept) begin
               state_n = guard ? DEFER : ARMED;
            end else if (multi) begin
               state_n = ARMED;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // vblnkst_q resets high so a blank already in progress is not taken as a rising edge.
   always_ff @(posedge hclock) begin
      if (hreset) begin
         state      <= IDLE;
         vblnkst_q  <= 1'b1;
         dstart_act <= '0;
         hst_ack    <= 1'b0;
         dlp_ack    <= 1'b0;
         lost_cnt   <= '0;
      end else begin
         state     <= state_n;
         vblnkst_q <= vblnkst;
         hst_ack   <= hst_wr;
         dlp_ack   <= dlp_wradd;
         lost_cnt  <= lost_sat_add(lost_cnt, lost_inc);
         if (state == COMMIT) begin
            dstart_act <= head_dat;
         end
      end
   end

   assign ad_strst  = (state == COMMIT);
   assign addr_stat = ~empty;

endmodule

// File: tb/tb_crt_dstart_sched.sv
// Bench for crt_dstart_sched: directed frames plus random traffic against a countdown reference model.
module tb_crt_dstart_sched;

   localparam int PRIO = 1;
   localparam int G    = 4;
   localparam int AW   = 21;

   logic          hclock = 1'b0;
   logic          hreset;
   logic          hst_wr;
   logic [AW-1:0] hst_add;
   logic          dlp_wradd;
   logic [AW-1:0] dlp_add;
   logic          vblnkst;
   logic [11:0]   lcounter_stat;
   logic [11:0]   vactive;
   logic [AW-1:0] dstart_act;
   logic          ad_strst;
   logic          addr_stat;
   logic          dlp_ack;
   logic          hst_ack;
   logic [7:0]    lost_cnt;

   crt_dstart_sched #(
      .DLP_PRIO    (PRIO),
      .GUARD_LINES (G),
      .AW          (AW)
   ) dut (
      .hclock        (hclock),
      .hreset        (hreset),
      .hst_wr        (hst_wr),
      .hst_add       (hst_add),
      .dlp_wradd     (dlp_wradd),
      .dlp_add       (dlp_add),
      .vblnkst       (vblnkst),
      .lcounter_stat (lcounter_stat),
      .vactive       (vactive),
      .dstart_act    (dstart_act),
      .ad_strst      (ad_strst),
      .addr_stat     (addr_stat),
      .dlp_ack       (dlp_ack),
      .hst_ack       (hst_ack),
      .lost_cnt      (lost_cnt)
   );

   always #5 hclock = ~hclock;

   int total = 0;
   int bad   = 0;

   // Reference model: a pending value plus the number of vblank rises it still has to see.
   logic          m_vq     = 1'b1;
   logic          m_pend   = 1'b0;
   logic [AW-1:0] m_val    = '0;
   int            m_wait   = 0;
   logic          m_commit = 1'b0;
   int            m_lost   = 0;
   logic          m_hack   = 1'b0;
   logic          m_dack   = 1'b0;
   logic [AW-1:0] exp_q[$];

   logic          dst_chk = 1'b0;
   logic [AW-1:0] dst_exp = '0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic h, input logic [AW-1:0] hd,
                             input logic d, input logic [AW-1:0] dd,
                             input logic vb, input int lc, input int va);
      logic          vbr, guard, acc, was, now;
      logic [AW-1:0] win;
      int            inc;
      if (r) begin
         m_vq = 1'b1; m_pend = 1'b0; m_commit = 1'b0; m_lost = 0;
         m_hack = 1'b0; m_dack = 1'b0; m_wait = 0;
         exp_q.delete();
         return;
      end
      vbr   = vb && !m_vq;
      m_vq  = vb;
      guard = (lc + G >= va) && !vb;
      acc   = h || d;
      win   = (h && d) ? ((PRIO != 0) ? dd : hd) : (h ? hd : dd);
      m_hack = h;
      m_dack = d;
      inc    = (h && d) ? 1 : 0;
      was      = m_commit;
      m_commit = 1'b0;
      now      = 1'b0;
      if (!was && m_pend && vbr) begin
         m_wait--;
         if (m_wait == 0) now = 1'b1;
      end
      if (acc) begin
         if (m_pend && !was) begin
            inc++;
            if (guard) m_wait = 2;
         end else begin
            m_pend = 1'b1;
            m_wait = guard ? 2 : 1;
         end
         m_val = win;
      end else if (was) begin
         m_pend = 1'b0;
      end
      m_lost = (m_lost + inc > 255) ? 255 : m_lost + inc;
      if (now) begin
         m_commit = 1'b1;
         exp_q.push_back(m_val);
      end
   endtask

   // Drive one cycle of inputs, then advance the model past the capturing edge.
   task automatic cyc(input logic r, input logic h, input logic [AW-1:0] hd,
                      input logic d, input logic [AW-1:0] dd,
                      input logic vb, input int lc);
      hreset = r; hst_wr = h; hst_add = hd; dlp_wradd = d; dlp_add = dd;
      vblnkst = vb; lcounter_stat = 12'(lc);
      @(posedge hclock);
      #1;
      model_step(r, h, hd, d, dd, vb, lc, int'(vactive));
   endtask

   task automatic idle(input logic vb, input int lc, input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0, vb, lc);
   endtask

   task automatic rand_frames(input int nf);
      logic h, d;
      for (int f = 0; f < nf; f++) begin
         for (int lc = 0; lc < 25; lc++) begin
            h = ($urandom_range(5) == 0);
            d = ($urandom_range(5) == 0);
            cyc(1'b0, h, AW'($urandom()), d, AW'($urandom()), lc >= 20, lc);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge hclock);
         if (dst_chk) begin
            cmp("dstart_act after commit", 32'(dstart_act), 32'(dst_exp));
            dst_chk = 1'b0;
         end
         cmp("ad_strst", 32'(ad_strst), 32'(m_commit));
         if (ad_strst && exp_q.size() > 0) begin
            dst_exp = exp_q.pop_front();
            dst_chk = 1'b1;
         end
         cmp("addr_stat", 32'(addr_stat), 32'(m_pend));
         cmp("lost_cnt", 32'(lost_cnt), 32'(m_lost));
         cmp("hst_ack", 32'(hst_ack), 32'(m_hack));
         cmp("dlp_ack", 32'(dlp_ack), 32'(m_dack));
      end
   end

   initial begin
      vactive = 12'd480;
      // Reset inside a blank, then stay in blank: nothing may commit.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 480);
      idle(1'b1, 480, 5);
      cmp("reset dstart_act", 32'(dstart_act), 32'h0);
      cmp("reset addr_stat", 32'(addr_stat), 32'h0);

      // Host write mid-frame commits at the next blank.
      cyc(1'b0, 1'b1, 21'h00100, 1'b0, '0, 1'b0, 10);
      idle(1'b0, 11, 3);
      cmp("pending after host write", 32'(addr_stat), 32'h1);
      idle(1'b1, 480, 4);
      cmp("host commit value", 32'(dstart_act), 32'h00100);
      cmp("host commit clears status", 32'(addr_stat), 32'h0);

      // Collision: DLP wins, host is acked but lost.
      cyc(1'b0, 1'b1, 21'h1, 1'b1, 21'h2, 1'b0, 20);
      idle(1'b0, 21, 3);
      idle(1'b1, 480, 4);
      cmp("collision winner", 32'(dstart_act), 32'h2);
      cmp("collision lost", 32'(lost_cnt), 32'd1);

      // Write inside the guard window waits one extra frame.
      cyc(1'b0, 1'b0, '0, 1'b1, 21'h333, 1'b0, 477);
      idle(1'b0, 478, 2);
      idle(1'b1, 480, 4);
      cmp("deferred not committed", 32'(dstart_act), 32'h2);
      cmp("deferred still pending", 32'(addr_stat), 32'h1);
      idle(1'b0, 0, 4);
      idle(1'b1, 480, 4);
      cmp("deferred commit", 32'(dstart_act), 32'h333);

      // Three writes in one frame: last writer wins.
      cyc(1'b0, 1'b1, 21'h11, 1'b0, '0, 1'b0, 5);
      cyc(1'b0, 1'b0, '0, 1'b1, 21'h22, 1'b0, 6);
      cyc(1'b0, 1'b1, 21'h44, 1'b0, '0, 1'b0, 7);
      idle(1'b0, 8, 2);
      idle(1'b1, 480, 4);
      cmp("last writer wins", 32'(dstart_act), 32'h44);
      cmp("three writes lost", 32'(lost_cnt), 32'd3);

      // Reset while armed drops the pending value.
      cyc(1'b0, 1'b1, 21'h55, 1'b0, '0, 1'b0, 10);
      idle(1'b0, 11, 2);
      cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 12);
      idle(1'b0, 13, 2);
      idle(1'b1, 480, 5);
      cmp("reset drops pending", 32'(dstart_act), 32'h0);

      // Random traffic on short frames so the guard window is hit often.
      vactive = 12'd20;
      rand_frames(40);

      // Back-to-back collisions drive the loss counter into saturation.
      for (int i = 0; i < 130; i++) cyc(1'b0, 1'b1, AW'(i), 1'b1, AW'(i + 1000), 1'b0, 5);
      cmp("lost_cnt saturates", 32'(lost_cnt), 32'd255);
      rand_frames(2);
      idle(1'b0, 0, 10);
      idle(1'b1, 20, 5);
      idle(1'b0, 0, 10);
      idle(1'b1, 20, 5);
      cmp("all commits observed", 32'(exp_q.size()), 32'd0);
      cmp("lost_cnt held at max", 32'(lost_cnt), 32'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/crt_dstart_sched.md
Name: crt_dstart_sched

Overview:
- Schedules display-start-address updates from two requesters, host and DLP, into the CRT display path.
- Holds each accepted request as pending and commits it only at the start of vertical blank. Requests that arrive inside a guard window just before blank are deferred to the next frame.
- Emits the one-hclock ad_strst pulse that clears the "display address updated" status bit, and exposes the pending status.
- Sits between the host/DLP write sources and the CRT register/timer blocks.

Parameters:
- DLP_PRIO, 0, 1 means a DLP request wins a same-cycle collision with a host request; 0 means the host wins.
- GUARD_LINES, 4, number of lines before vactive in which a new commit is not armed for the current frame.
- AW, 21, address width; carries bits [24:4].

Ports:
- hclock  in  1  sole clock.
- hreset  in  1  synchronous, active-high reset.
- hst_wr  in  1  host write strobe for the display-start register; pulse.
- hst_add  in  AW  host address value.
- dlp_wradd  in  1  DLP write strobe; pulse.
- dlp_add  in  AW  DLP address value.
- vblnkst  in  1  synchronized vertical-blank level.
- lcounter_stat  in  12  current line, synchronized.
- vactive  in  12  active line count.
- dstart_act  out  AW  committed display start used by the CRT.
- ad_strst  out  1  one-cycle pulse on commit.
- addr_stat  out  1  an update is pending and not yet committed.
- dlp_ack  out  1  one-cycle pulse: DLP request accepted.
- hst_ack  out  1  one-cycle pulse: host request accepted.
- lost_cnt  out  8  count of requests overwritten before commit; saturating.

Behaviour:
- Reset (hreset high at a clock edge): dstart_act=0, pending=0, state=IDLE, all pulse outputs 0, lost_cnt=0. Reset mid-commit discards the pending value.
- vb_rise = vblnkst & ~vblnkst_q; vblnkst_q is a registered copy, reset value 1 so a blank in progress at reset produces no spurious edge.
- guard = (lcounter_stat + GUARD_LINES >= vactive) & ~vblnkst, computed at 13 bits; no wrap.
- Acceptance: any request is accepted in the cycle it is strobed. Its ack pulses on the next cycle. pend_add <= winner data.
- Collision: when both strobes are high, the DLP_PRIO winner is stored. The loser is still acked, increments lost_cnt, and its data is dropped.
- A request that arrives while an update is already pending overwrites it (last-writer-wins) and increments lost_cnt. lost_cnt saturates at 255.

FSM states:
- IDLE: accept -> ARMED if guard=0; DEFER if guard=1.
- ARMED: vb_rise -> COMMIT.
- DEFER: waits for vb_rise of the current frame without committing, then -> ARMED, so the commit happens at the next frame's vb_rise.
- COMMIT: one cycle. dstart_act <= pend_add, ad_strst=1, pending cleared -> IDLE.
- A request accepted in the COMMIT cycle is not lost: it is re-stored as pending and the next state is ARMED/DEFER by guard.
- A new request in ARMED that lands inside the guard window moves the state to DEFER.

Status and latency:
- addr_stat = 1 in ARMED and DEFER, registered. Reads 1 from the cycle after accept through the COMMIT cycle; 0 the cycle after.
- Latency from accept to dstart_act update: the first vb_rise after accept plus one cycle, or the second vb_rise if deferred.

Optional Feature:
- Macro CRT_DSTART_FIFO_EN.
- Defined: pending storage is a 4-entry FIFO instead of a single slot.
  - One entry is committed per vb_rise.
  - addr_stat = FIFO not empty.
  - A push when full overwrites the newest entry and increments lost_cnt.
  - Commit and push in the same cycle are both honoured.
- Undefined: single-slot, last-writer-wins as above.

Decomposition:
- Package crt_sp_pkg holds:
  - FSM state enum: IDLE, ARMED, DEFER, COMMIT.
  - Localparams CRT_DSTART_AW=21 and CRT_DSTART_FIFO_DEPTH=4.
  - Lost-counter saturation max.
- One natural sub-module, crt_dstart_fifo: storage with push/pop/full/empty. In single-slot builds it is compiled as depth 1.

Test Plan:
- Reset with vblnkst=1, then deassert reset and hold vblnkst=1 -> no ad_strst; dstart_act=0; addr_stat=0.
- Host write 0x00100 at line 10 (vactive=480), then vblnkst rises -> ad_strst pulses one cycle after the edge; dstart_act=0x00100; addr_stat 1->0.
- Same-cycle hst_wr=0x1 and dlp_wradd=0x2 with DLP_PRIO=1 -> both acks pulse; dstart_act=0x2 at vblank; lost_cnt=1.
- DLP write at line 477 (guard window, GUARD_LINES=4) -> no commit at that frame's vblank; commit at the next frame's vblank.
- Three writes in one frame -> only the last commits; lost_cnt=2. With CRT_DSTART_FIFO_EN: the three commit over three consecutive frames.
- Assert hreset while ARMED -> pending dropped; no ad_strst at the following vblank.
